// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the E stage: fixed-latency mult/div, mthi/mtlo, mfhi/mflo.
// Define MDU_MADD_EN to add madd (mdOp 9) and msub (mdOp 10) accumulate operations.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hiloData,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int cnt_w   = $clog2(max_cyc + 1);

  logic [cnt_w-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_we;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;

  logic             launch;
  logic             commit_n;
  logic [63:0]      res_n;
  logic [cnt_w-1:0] cyc_n;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes: quotient truncates toward zero, remainder follows
  // the dividend. 0x80000000 / -1 falls out naturally as quotient 0x80000000.
  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign r_s   = A[31] ? -r_mag : r_mag;

  always_comb begin
    launch   = 1'b0;
    commit_n = 1'b1;
    res_n    = '0;
    cyc_n    = cnt_w'(MULT_CYCLES);
    case (mdOp)
      4'd1: begin launch = 1'b1; res_n = prod_s; end
      4'd2: begin launch = 1'b1; res_n = prod_u; end
      4'd3: begin
        launch   = 1'b1;
        cyc_n    = cnt_w'(DIV_CYCLES);
        res_n    = {r_s, q_s};
        commit_n = |B;
      end
      4'd4: begin
        launch   = 1'b1;
        cyc_n    = cnt_w'(DIV_CYCLES);
        res_n    = {A % B, A / B};
        commit_n = |B;
      end
`ifdef MDU_MADD_EN
      4'd9:  begin launch = 1'b1; res_n = {HI, LO} + prod_s; end
      4'd10: begin launch = 1'b1; res_n = {HI, LO} - prod_s; end
`endif
      default: ;
    endcase
    launch = launch & start & ~busy;
  end

  // Result is computed at launch and held in pend; HI/LO only change at the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      cnt     <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
    end else if (cnt != '0) begin
      if (cnt == cnt_w'(1)) begin
        cnt <= '0;
        if (pend_we) {HI, LO} <= pend;
      end else begin
        cnt <= cnt - cnt_w'(1);
      end
    end else if (launch) begin
      cnt     <= cyc_n;
      pend    <= res_n;
      pend_we <= commit_n;
    end else if (mdOp == 4'd7) begin
      HI <= A;
    end else if (mdOp == 4'd8) begin
      LO <= A;
    end
  end

  assign busy     = (cnt != '0);
  assign hiloData = (mdOp == 4'd5) ? HI : (mdOp == 4'd6) ? LO : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected {HI,LO} and busy length queued at launch,
// popped by a monitor on each busy falling edge.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hiloData, HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  int          len_q[$];
  int          busy_len = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp), .A(A), .B(B),
    .busy(busy), .hiloData(hiloData), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_q.push_back({hi, lo});
    len_q.push_back(len);
  endtask

  // Applies one set of inputs for exactly one rising edge.
  task automatic op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                    input logic st);
    mdOp = code; A = a; B = b; start = st;
    @(posedge clk); #1;
    mdOp = 4'd0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: busy still %b after 40 cycles, expected 0", name, busy);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0;
    end else if (busy) begin
      busy_len++;
    end else if (busy_len != 0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got HI=%h LO=%h, expected no completion", HI, LO);
      end else begin
        logic [63:0] e;
        int          l;
        e = exp_q.pop_front();
        l = len_q.pop_front();
        check("result_hi", HI, e[63:32]);
        check("result_lo", LO, e[31:0]);
        check("busy_len", 32'(busy_len), 32'(l));
      end
      busy_len = 0;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = 4'd0; A = '0; B = '0;
    idle(2);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // mult / multu of 0xFFFFFFFF * 2
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_idle("mult_idle");
    expect_result(32'h00000001, 32'hFFFFFFFE, 5);
    op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_idle("multu_idle");

    // signed/unsigned divide, including negative divisor and the overflow case
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle("div_idle");
    expect_result(32'd1, 32'd3, 10);
    op(4'd4, 32'd7, 32'd2, 1'b1);
    wait_idle("divu_idle");
    expect_result(32'd1, 32'hFFFFFFFD, 10);
    op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1);
    wait_idle("div_negb_idle");
    expect_result(32'd0, 32'h80000000, 10);
    op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle("div_ovf_idle");

    // mthi, then combinational reads
    op(4'd7, 32'h12345678, 32'd0, 1'b0);
    mdOp = 4'd5; #1;
    check("mfhi", hiloData, 32'h12345678);
    mdOp = 4'd6; #1;
    check("mflo", hiloData, 32'h80000000);
    mdOp = 4'd0; #1;
    check("hilo_none", hiloData, 32'd0);

    // divide by zero leaves HI/LO untouched after the full busy period
    expect_result(32'h12345678, 32'h80000000, 10);
    op(4'd3, 32'd5, 32'd0, 1'b1);
    wait_idle("div0_idle");

    // start with a non-launch code does nothing
    op(4'd5, 32'd1, 32'd1, 1'b1);
    check("nonlaunch_busy", {31'd0, busy}, 32'd0);

    // mtlo and a second start while busy are ignored
    op(4'd7, 32'd0, 32'd0, 1'b0);
    expect_result(32'd0, 32'd12, 5);
    op(4'd1, 32'd3, 32'd4, 1'b1);
    mdOp = 4'd5; #1;
    check("mfhi_while_busy", hiloData, 32'd0);
    op(4'd8, 32'h0000DEAD, 32'd0, 1'b0);
    op(4'd3, 32'd9, 32'd2, 1'b1);
    wait_idle("busy_ignore_idle");

    // reset mid-operation discards the pending result
    op(4'd1, 32'd3, 32'd4, 1'b1);
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", HI, 32'd0);
    check("midreset_lo", LO, 32'd0);
    idle(8);
    check("postreset_hi", HI, 32'd0);
    check("postreset_lo", LO, 32'd0);

    // accumulate ops
    op(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    expect_result(32'd1, 32'd0, 5);
    op(4'd9, 32'd1, 32'd1, 1'b1);
    wait_idle("madd_idle");
    expect_result(32'd0, 32'hFFFFFFFA, 5);
    op(4'd10, 32'd2, 32'd3, 1'b1);
    wait_idle("msub_idle");
`else
    op(4'd9, 32'd1, 32'd1, 1'b1);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    op(4'd10, 32'd2, 32'd3, 1'b1);
    check("msub_off_busy", {31'd0, busy}, 32'd0);
    idle(6);
    check("madd_off_hi", HI, 32'd0);
    check("madd_off_lo", LO, 32'hFFFFFFFF);
`endif

    idle(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- HI/LO multiply-divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI and LO registers.
- Serves mfhi/mflo reads, which travel down the pipe and become W_hiloData at the W-stage write-back select.
- Handles mthi/mtlo writes.
- Exports busy so the hazard unit can stall md-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that launches a mult/multu/div/divu (or madd/msub) given by mdOp.
- mdOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 msub. Codes 11-15 are no-ops.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  high while an operation is in flight.
- hiloData  output  32  combinational read: HI when mdOp=5, LO when mdOp=6, otherwise 0.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (synchronous, active-high): on a clk edge with reset=1, HI=0, LO=0, busy=0, counter=0, and any pending result is discarded. Reset has priority over every other input, including mid-operation.
- Launch:
  - Condition: a clk edge where start=1, busy=0 and mdOp is in 1-4 (or 9-10 when the feature is enabled).
  - Operands A and B are latched; the full result is computed into internal pending HI/LO.
  - counter is loaded with N (MULT_CYCLES for mult-class, DIV_CYCLES for div-class); busy goes to 1.
- Countdown:
  - Each later edge with counter>1 decrements counter.
  - At the edge where counter==1: pending values are committed to HI/LO, counter goes to 0, busy goes to 0.
  - busy is therefore high for exactly N cycles; new HI/LO are visible in the first cycle busy is low.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0 on div/divu): busy sequence runs normally for DIV_CYCLES, then HI/LO are left unchanged.
- div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: on an edge with mdOp=7 (or 8) and busy=0, HI (or LO) takes A. start is not required. Ignored while busy=1.
- start while busy=1: ignored. The in-flight operation is unaffected.
- start with mdOp outside the launch set: no effect.
- mfhi/mflo: pure combinational read of the current registers, with no register bypass. While busy=1 they return the old values; the hazard unit must stall them.
- Stall contract: the hazard unit stalls any md-class instruction in D when (start | busy).
- mdOp=0: HI, LO and counter hold.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - mdOp 9 (madd): {HI,LO} <= {HI,LO} + signed(A*B).
  - mdOp 10 (msub): {HI,LO} <= {HI,LO} - signed(A*B).
  - Both use 64-bit wrap-around arithmetic and MULT_CYCLES latency.
  - The accumulator base is the {HI,LO} sampled at the launch edge.
- Not defined: mdOp 9 and 10 are no-ops, start with them is ignored, and busy stays 0.

Test Plan:
1. mult, A=0xFFFFFFFF, B=0x00000002, start for 1 cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same stimulus as multu -> HI=0x00000001, LO=0xFFFFFFFE.
2. div A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
3. mthi A=0x12345678, then mflo/mfhi -> hiloData=0x12345678 for mfhi. Then div A=5, B=0 -> after 10 busy cycles HI=0x12345678 and LO unchanged.
4. mult A=3, B=4 launched; at busy cycle 2 apply mtlo A=0xDEAD and a second start (div) -> both ignored; after completion HI=0, LO=12, busy=0.
5. mult A=3, B=4 launched; reset asserted at busy cycle 3 -> next cycle busy=0, HI=LO=0, and no later commit occurs.
6. With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> busy stays 0 and HI/LO are unchanged.
